// File: rtl/debug_dump_sequencer.sv
// Streams PC, register file and a data-memory window LSB-first over the UART byte interface.
// Optional: define DEBUG_DUMP_STEP_COUNT_EN to append a dump step counter as the final word.
module debug_dump_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int NB_REGS         = 32,
    parameter int NB_MEM_WORDS    = 16,
    localparam int REG_AW = (NB_REGS > 1) ? $clog2(NB_REGS) : 1,
    localparam int MEM_AW = (NB_MEM_WORDS > 1) ? $clog2(NB_MEM_WORDS) : 1
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_dump_req,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    output logic [REG_AW-1:0]          o_reg_addr,
    input  logic [DATA_WIDTH-1:0]      i_reg_data,
    output logic [MEM_AW-1:0]          o_mem_addr,
    input  logic [DATA_WIDTH-1:0]      i_mem_data,
    input  logic                       i_tx_available,
    input  logic                       i_tx_done,
    output logic                       o_tx_signal,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    output logic                       o_busy,
    output logic                       o_dump_done
);

    localparam int BPW = DATA_WIDTH / DATA_WIDTH_UART;
`ifdef DEBUG_DUMP_STEP_COUNT_EN
    localparam int WORDS = 2 + NB_REGS + NB_MEM_WORDS;
`else
    localparam int WORDS = 1 + NB_REGS + NB_MEM_WORDS;
`endif
    localparam int WIDX_W = $clog2(WORDS);
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_SEND,
        S_WAIT_TX,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic [DATA_WIDTH-1:0]      pc_q;
    logic [DATA_WIDTH-1:0]      shift_q;
    logic [WIDX_W-1:0]          word_q;
    logic [BIDX_W-1:0]          byte_q;
    logic [REG_AW-1:0]          reg_addr_q;
    logic [MEM_AW-1:0]          mem_addr_q;
    logic                       tx_signal_q;
    logic [DATA_WIDTH_UART-1:0] tx_byte_q;
    logic                       busy_q;
    logic                       dump_done_q;
`ifdef DEBUG_DUMP_STEP_COUNT_EN
    logic [DATA_WIDTH-1:0]      step_q;
`endif

    int unsigned                word_cur;
    int unsigned                word_nxt;
    logic [REG_AW-1:0]          reg_addr_d;
    logic [MEM_AW-1:0]          mem_addr_d;

    // Addresses for the next word are registered on entry to LOAD so the
    // one-cycle read latency is satisfied by the time CAPTURE samples.
    always_comb begin
        word_cur   = 32'(word_q);
        word_nxt   = word_cur + 1;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        if (word_nxt >= 1 && word_nxt <= NB_REGS) begin
            reg_addr_d = REG_AW'(word_nxt - 1);
        end else if (word_nxt > NB_REGS && word_nxt <= NB_REGS + NB_MEM_WORDS) begin
            mem_addr_d = MEM_AW'(word_nxt - 1 - NB_REGS);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            byte_q      <= '0;
            reg_addr_q  <= '0;
            mem_addr_q  <= '0;
            tx_signal_q <= 1'b0;
            tx_byte_q   <= '0;
            busy_q      <= 1'b0;
            dump_done_q <= 1'b0;
`ifdef DEBUG_DUMP_STEP_COUNT_EN
            step_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (i_dump_req) begin
                        pc_q       <= i_pc;
                        word_q     <= '0;
                        byte_q     <= '0;
                        reg_addr_q <= '0;
                        mem_addr_q <= '0;
                        busy_q     <= 1'b1;
`ifdef DEBUG_DUMP_STEP_COUNT_EN
                        step_q     <= step_q + 1'b1;
`endif
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (word_cur == 0) begin
                        shift_q <= pc_q;
                    end else if (word_cur <= NB_REGS) begin
                        shift_q <= i_reg_data;
`ifdef DEBUG_DUMP_STEP_COUNT_EN
                    end else if (word_cur <= NB_REGS + NB_MEM_WORDS) begin
                        shift_q <= i_mem_data;
                    end else begin
                        shift_q <= step_q;
                    end
`else
                    end else begin
                        shift_q <= i_mem_data;
                    end
`endif
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (i_tx_available) begin
                        tx_signal_q <= 1'b1;
                        tx_byte_q   <= shift_q[DATA_WIDTH_UART-1:0];
                        state_q     <= S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    tx_signal_q <= 1'b0;
                    if (i_tx_done) begin
                        if (byte_q == BIDX_W'(BPW - 1)) begin
                            byte_q <= '0;
                            if (word_q == WIDX_W'(WORDS - 1)) begin
                                dump_done_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                word_q     <= word_q + 1'b1;
                                reg_addr_q <= reg_addr_d;
                                mem_addr_q <= mem_addr_d;
                                state_q    <= S_LOAD;
                            end
                        end else begin
                            byte_q  <= byte_q + 1'b1;
                            shift_q <= shift_q >> DATA_WIDTH_UART;
                            state_q <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    dump_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_reg_addr  = reg_addr_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_tx_signal = tx_signal_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_busy      = busy_q;
    assign o_dump_done = dump_done_q;

endmodule
